// File: rtl/axi_slave_read_pkg.sv
// Shared definitions for the AXI4 -> AXI-lite read bridge: response and burst
// codes, plus the burst-tracking FIFO entry layout.
package axi_slave_read_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_t;

  // Entries carry the widest supported ID; the top keeps only its low bits.
  localparam int FIFO_ID_W = 8;

  typedef struct packed {
    logic [FIFO_ID_W-1:0] id;
    logic [7:0]           len;
  } burst_entry_t;

endpackage

// File: rtl/axi_addr.sv
// Burst next-address calculator shared by the read and write bridges:
// FIXED holds, INCR steps by 2^size (aligned), WRAP wraps at (len+1)*2^size.
module axi_addr
  import axi_slave_read_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic [AW-1:0] last_addr,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  input  logic [7:0]    len,
  output logic [AW-1:0] next_addr
);

  // Wide enough for a 256-beat x 128-byte wrap window without overflow.
  localparam int XW = AW + 16;

  logic [XW-1:0] incr, wrap_mask, aligned, bumped;

  always_comb begin
    incr      = XW'(1) << size;
    wrap_mask = ((XW'(len) + XW'(1)) << size) - XW'(1);
    aligned   = XW'(last_addr) & ~(incr - XW'(1));
    bumped    = aligned + incr;
    next_addr = last_addr;
    case (burst)
      BURST_INCR: next_addr = bumped[AW-1:0];
      BURST_WRAP: next_addr = AW'((XW'(last_addr) & ~wrap_mask) | (bumped & wrap_mask));
      default:    next_addr = last_addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_read.sv
// AXI4 read slave that splits each burst into single AXI-lite reads and
// reassembles the data into R beats. Optional: AXI_SLAVE_READ_RSKID_EN.
module axi_slave_read
  import axi_slave_read_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 2,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 6,
  parameter int LGFIFO           = 4
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARLOCK,
  input  logic [3:0]                  S_AXI_ARCACHE,
  input  logic [2:0]                  S_AXI_ARPROT,
  input  logic [3:0]                  S_AXI_ARQOS,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP
);

  // Handshakes: a transfer happens on a rising edge where VALID && READY;
  // VALID never waits on READY, and payload holds while VALID && !READY.
  localparam int DW    = C_AXI_DATA_WIDTH;
  localparam int DEPTH = 1 << LGFIFO;

  logic [C_AXI_ADDR_WIDTH-1:0] ar_addr, next_addr;
  logic [7:0]   ar_len, arcnt, rcnt;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic         m_arvalid, last_ar_hs, burst_active, ar_accept;
  burst_entry_t fifo_mem [DEPTH];
  burst_entry_t head;
  logic [LGFIFO:0] wr_ptr, rd_ptr;
  logic         fifo_full, pop;
  logic         ld, ld_last;
  logic [DW-1:0] ld_data;
  logic [1:0]   ld_resp;
  logic         unused_ok;

  assign unused_ok = ^{S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, head};

  assign last_ar_hs    = m_arvalid && M_AXI_ARREADY && (arcnt == 8'd0);
  assign burst_active  = m_arvalid && !last_ar_hs;
  assign fifo_full     = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                         (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
  assign S_AXI_ARREADY = !S_AXI_ARESET && !burst_active && !fifo_full;
  assign ar_accept     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign M_AXI_ARVALID = m_arvalid;
  assign M_AXI_ARADDR  = ar_addr;
  assign M_AXI_ARPROT  = 3'd0;

  axi_addr #(.AW(C_AXI_ADDR_WIDTH)) u_axi_addr (
    .last_addr (ar_addr),
    .size      (ar_size),
    .burst     (ar_burst),
    .len       (ar_len),
    .next_addr (next_addr)
  );

  // A new burst wins over the final address handshake of the previous one.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      m_arvalid <= 1'b0;
      arcnt     <= 8'd0;
      ar_addr   <= '0;
      ar_len    <= 8'd0;
      ar_size   <= 3'd0;
      ar_burst  <= 2'd0;
    end else if (ar_accept) begin
      m_arvalid <= 1'b1;
      arcnt     <= S_AXI_ARLEN;
      ar_addr   <= S_AXI_ARADDR;
      ar_len    <= S_AXI_ARLEN;
      ar_size   <= S_AXI_ARSIZE;
      ar_burst  <= S_AXI_ARBURST;
    end else if (m_arvalid && M_AXI_ARREADY) begin
      ar_addr <= next_addr;
      if (arcnt == 8'd0) m_arvalid <= 1'b0;
      else               arcnt     <= arcnt - 8'd1;
    end
  end

  assign head    = fifo_mem[rd_ptr[LGFIFO-1:0]];
  assign ld_last = (rcnt == head.len);
  assign pop     = ld && ld_last;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (ar_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (ar_accept)
      fifo_mem[wr_ptr[LGFIFO-1:0]] <= '{id: FIFO_ID_W'(S_AXI_ARID), len: S_AXI_ARLEN};
  end

`ifdef AXI_SLAVE_READ_RSKID_EN
  logic [DW+1:0] sk_mem [2];
  logic          sk_rd, sk_wr, rready_q, in_hs, out_ok, sk_push, sk_pop;
  logic [1:0]    sk_cnt, sk_cnt_next;

  // Lite beats bypass the skid entries whenever they are empty and R can load.
  assign M_AXI_RREADY       = rready_q && !S_AXI_ARESET;
  assign in_hs              = M_AXI_RVALID && M_AXI_RREADY;
  assign out_ok             = !S_AXI_RVALID || S_AXI_RREADY;
  assign ld                 = out_ok && ((sk_cnt != 2'd0) || in_hs);
  assign {ld_resp, ld_data} = (sk_cnt != 2'd0) ? sk_mem[sk_rd] : {M_AXI_RRESP, M_AXI_RDATA};
  assign sk_pop             = ld && (sk_cnt != 2'd0);
  assign sk_push            = in_hs && ((sk_cnt != 2'd0) || !out_ok);
  assign sk_cnt_next        = sk_cnt + {1'b0, sk_push} - {1'b0, sk_pop};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      sk_cnt   <= 2'd0;
      sk_rd    <= 1'b0;
      sk_wr    <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      sk_cnt   <= sk_cnt_next;
      rready_q <= (sk_cnt_next != 2'd2);
      if (sk_push) sk_wr <= ~sk_wr;
      if (sk_pop)  sk_rd <= ~sk_rd;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (sk_push) sk_mem[sk_wr] <= {M_AXI_RRESP, M_AXI_RDATA};
  end
`else
  assign M_AXI_RREADY = !S_AXI_ARESET && (!S_AXI_RVALID || S_AXI_RREADY);
  assign ld           = M_AXI_RVALID && M_AXI_RREADY;
  assign ld_data      = M_AXI_RDATA;
  assign ld_resp      = M_AXI_RRESP;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RID    <= '0;
      S_AXI_RLAST  <= 1'b0;
      rcnt         <= 8'd0;
    end else if (ld) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= ld_data;
      S_AXI_RRESP  <= ld_resp;
      S_AXI_RID    <= head.id[C_AXI_ID_WIDTH-1:0];
      S_AXI_RLAST  <= ld_last;
      rcnt         <= ld_last ? 8'd0 : rcnt + 8'd1;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_slave_read.sv
// Bench for axi_slave_read: directed burst table, FIFO-full, mid-burst reset
// and randomized bursts against an arithmetic address/beat model.
module tb_axi_slave_read;
  import axi_slave_read_pkg::*;

  localparam int IDW = 2;
  localparam int DW  = 32;
  localparam int AW  = 6;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
  } req_t;

  typedef struct packed {
    req_t               r;
    logic [1:0]         rmode;
    logic               drain;
    logic [3:0][AW-1:0] ea;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic s_arvalid, s_arready, s_arlock;
  logic [IDW-1:0] s_arid, s_rid;
  logic [AW-1:0] s_araddr, m_araddr;
  logic [7:0] s_arlen;
  logic [2:0] s_arsize, s_arprot, m_arprot;
  logic [1:0] s_arburst, s_rresp, m_rresp;
  logic [3:0] s_arcache, s_arqos;
  logic s_rvalid, s_rready, s_rlast, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] s_rdata, m_rdata;

  always #5 clk = ~clk;

  axi_slave_read dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready), .S_AXI_ARID(s_arid),
    .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen), .S_AXI_ARSIZE(s_arsize),
    .S_AXI_ARBURST(s_arburst), .S_AXI_ARLOCK(s_arlock), .S_AXI_ARCACHE(s_arcache),
    .S_AXI_ARPROT(s_arprot), .S_AXI_ARQOS(s_arqos),
    .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready), .S_AXI_RID(s_rid),
    .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RLAST(s_rlast),
    .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready), .M_AXI_ARADDR(m_araddr),
    .M_AXI_ARPROT(m_arprot), .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready),
    .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  req_t           ar_q[$];
  logic [IDW:0]   exp_q[$];      // {rid, rlast} per expected R beat
  logic [DW+1:0]  exp_dq[$];     // {rresp, rdata} as issued by the lite slave
  logic [AW-1:0]  exp_addr_q[$];
  logic [AW-1:0]  lite_pend_q[$];
  logic [1:0]     resp_q[$];
  int  rmode, accepted, sbeats, lite_serial;
  bit  tog, lite_rand, lite_hold, lite_rhs_prev, saw_lite_rhs, obs_arready, prev_stall;
  logic [IDW+DW+2:0] prev_payload;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    total++;
    bad++;
    $display("FAIL %s: expected event missing", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] model_addr(req_t r, int i);
    int bytes = 1 << r.size;
    int a = int'(r.addr);
    int span, base;
    case (r.burst)
      BURST_FIXED: return r.addr;
      BURST_WRAP: begin
        span = (int'(r.len) + 1) * bytes;
        base = (a / span) * span;
        return AW'(base + ((a - base) + i * bytes) % span);
      end
      default: return (i == 0) ? r.addr : AW'((a / bytes) * bytes + i * bytes);
    endcase
  endfunction

  task automatic submit(req_t r);
    ar_q.push_back(r);
    for (int i = 0; i <= int'(r.len); i++) begin
      exp_addr_q.push_back(model_addr(r, i));
      exp_q.push_back({r.id, i == int'(r.len)});
    end
  endtask

  task automatic submit_tbl(vec_t v);
    ar_q.push_back(v.r);
    for (int i = 0; i <= int'(v.r.len); i++) begin
      exp_addr_q.push_back(v.ea[i]);
      exp_q.push_back({v.r.id, i == int'(v.r.len)});
    end
  endtask

  // ---------------- driver / monitor: one clock per call ----------------
  task automatic step();
    @(negedge clk);
    if (ar_q.size() > 0) begin
      s_arvalid = 1'b1;
      {s_arid, s_araddr, s_arlen, s_arsize, s_arburst} = ar_q[0];
    end else begin
      s_arvalid = 1'b0;
    end
    case (rmode)
      0: s_rready = 1'b1;
      1: s_rready = 1'($urandom_range(0, 1));
      default: begin s_rready = tog; tog = !tog; end
    endcase
    m_arready = lite_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!(m_rvalid && !lite_rhs_prev)) begin
      m_rvalid = 1'b0;
      if (lite_pend_q.size() > 0 && !lite_hold && (!lite_rand || $urandom_range(0, 2) != 0)) begin
        m_rvalid = 1'b1;
        m_rdata  = {16'(lite_serial), 10'd0, lite_pend_q[0]};
        lite_serial++;
        if (resp_q.size() > 0) m_rresp = resp_q.pop_front();
        else m_rresp = lite_rand ? 2'($urandom_range(0, 3)) : RESP_OKAY;
      end
    end
    #1;
    lite_rhs_prev = 1'b0;
    obs_arready   = s_arready;
    if (s_arvalid && s_arready) begin
      void'(ar_q.pop_front());
      accepted++;
    end
    if (m_arvalid && m_arready) begin
      if (exp_addr_q.size() == 0) fail("lite_addr_extra");
      else chk("lite_addr", 64'(m_araddr), 64'(exp_addr_q.pop_front()));
      lite_pend_q.push_back(m_araddr);
    end
    if (m_rvalid && m_rready) begin
      lite_rhs_prev = 1'b1;
      saw_lite_rhs  = 1'b1;
      void'(lite_pend_q.pop_front());
      exp_dq.push_back({m_rresp, m_rdata});
    end
    if (s_rvalid) begin
      if (prev_stall) chk("r_hold", 64'({s_rid, s_rlast, s_rresp, s_rdata}), 64'(prev_payload));
      if (s_rready) begin
        sbeats++;
        if (exp_q.size() == 0 || exp_dq.size() == 0) fail("r_beat_extra");
        else begin
          chk("rid_rlast", 64'({s_rid, s_rlast}), 64'(exp_q.pop_front()));
          chk("rresp_rdata", 64'({s_rresp, s_rdata}), 64'(exp_dq.pop_front()));
        end
      end
    end
    prev_stall   = s_rvalid && !s_rready;
    prev_payload = {s_rid, s_rlast, s_rresp, s_rdata};
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((ar_q.size() != 0 || exp_q.size() != 0 || exp_addr_q.size() != 0 ||
            lite_pend_q.size() != 0 || m_rvalid) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) fail("drain_timeout");
    chk("leftover_data", 64'(exp_dq.size()), 64'd0);
  endtask

  task automatic apply_reset(int n);
    @(negedge clk);
    rst = 1'b1; s_arvalid = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0; s_rready = 1'b1;
    ar_q.delete(); exp_q.delete(); exp_dq.delete(); exp_addr_q.delete();
    lite_pend_q.delete(); resp_q.delete();
    prev_stall = 1'b0; lite_rhs_prev = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  function automatic vec_t mk(int id, int addr, int len, int size, logic [1:0] burst, int rmode_v,
                              int drain_v, int a0, int a1, int a2, int a3);
    vec_t v;
    v.r.id = IDW'(id); v.r.addr = AW'(addr); v.r.len = 8'(len); v.r.size = 3'(size);
    v.r.burst = burst; v.rmode = 2'(rmode_v); v.drain = 1'(drain_v);
    v.ea[0] = AW'(a0); v.ea[1] = AW'(a1); v.ea[2] = AW'(a2); v.ea[3] = AW'(a3);
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[5];
    req_t r;
    int n;

    rst = 1'b1; s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_arburst = '0; s_arlock = 1'b0; s_arcache = '0; s_arprot = '0; s_arqos = '0;
    s_rready = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    rmode = 0; tog = 1'b1; lite_rand = 1'b0; lite_hold = 1'b0; lite_serial = 1;
    accepted = 0; sbeats = 0; saw_lite_rhs = 1'b0; prev_stall = 1'b0; lite_rhs_prev = 1'b0;
    prev_payload = '0; obs_arready = 1'b0;

    apply_reset(3);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_rlast", 64'(s_rlast), 64'd0);
    chk("rst_rdata_rid_rresp", 64'({s_rdata, s_rid, s_rresp}), 64'd0);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_m_rready", 64'(m_rready), 64'd0);
    chk("rst_m_arprot", 64'(m_arprot), 64'd0);
    release_reset();
    chk("arready_after_rst", 64'(s_arready), 64'd1);

    // Directed bursts: INCR, WRAP, FIXED with 0,2,0 responses, back-to-back.
    tbl[0] = mk(1, 'h00, 3, 2, BURST_INCR,  0, 1, 'h00, 'h04, 'h08, 'h0C);
    tbl[1] = mk(2, 'h08, 3, 2, BURST_WRAP,  0, 1, 'h08, 'h0C, 'h00, 'h04);
    tbl[2] = mk(0, 'h10, 2, 2, BURST_FIXED, 0, 1, 'h10, 'h10, 'h10, 0);
    tbl[3] = mk(0, 'h20, 0, 2, BURST_INCR,  2, 0, 'h20, 0, 0, 0);
    tbl[4] = mk(3, 'h30, 1, 2, BURST_INCR,  2, 1, 'h30, 'h34, 0, 0);
    for (int k = 0; k < 5; k++) begin
      rmode = int'(tbl[k].rmode);
      tog   = 1'b1;
      if (k == 2) begin
        resp_q.push_back(2'd0); resp_q.push_back(2'd2); resp_q.push_back(2'd0);
      end
      submit_tbl(tbl[k]);
      if (tbl[k].drain) drain(500);
    end

    // Fill all 16 tracking slots while the lite slave withholds data.
    rmode = 0; lite_hold = 1'b1; accepted = 0;
    for (int k = 0; k < 17; k++) begin
      r.id = IDW'(k); r.addr = AW'(4 * k); r.len = 8'd0; r.size = 3'd2; r.burst = BURST_INCR;
      submit(r);
    end
    n = 0;
    while (accepted < 16 && n < 200) begin step(); n++; end
    if (accepted < 16) fail("fill_timeout");
    repeat (4) begin
      step();
      chk("arready_full", 64'(obs_arready), 64'd0);
    end
    chk("ar_pending_when_full", 64'(ar_q.size()), 64'd1);
    lite_hold = 1'b0; saw_lite_rhs = 1'b0; n = 0;
    while (!saw_lite_rhs && n < 20) begin
      step();
      n++;
      chk("arready_before_pop", 64'(obs_arready), 64'd0);
    end
    if (!saw_lite_rhs) fail("lite_release_timeout");
    step();
    chk("arready_after_pop", 64'(obs_arready), 64'd1);
    drain(500);

    // Reset in the middle of an 8-beat burst, then a clean burst.
    lite_rand = 1'b1; rmode = 0; sbeats = 0;
    r.id = 2'd2; r.addr = '0; r.len = 8'd7; r.size = 3'd2; r.burst = BURST_INCR;
    submit(r);
    n = 0;
    while (sbeats < 3 && n < 200) begin step(); n++; end
    if (sbeats < 3) fail("midburst_timeout");
    apply_reset(1);
    chk("midrst_rvalid", 64'(s_rvalid), 64'd0);
    chk("midrst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("midrst_m_rready", 64'(m_rready), 64'd0);
    release_reset();
    chk("midrst_arready", 64'(s_arready), 64'd1);
    chk("midrst_rvalid_idle", 64'(s_rvalid), 64'd0);
    r.id = 2'd1; r.addr = 6'h04; r.len = 8'd3; r.size = 3'd2; r.burst = BURST_INCR;
    submit(r);
    drain(500);

    // Randomized bursts with random backpressure on both sides.
    rmode = 1; lite_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      r.id    = IDW'($urandom);
      r.size  = 3'($urandom_range(0, 2));
      r.burst = 2'($urandom_range(0, 2));
      r.len   = (r.burst == BURST_WRAP) ? 8'((2 << $urandom_range(0, 3)) - 1)
                                        : 8'($urandom_range(0, 9));
      r.addr  = AW'($urandom_range(0, 63)) & ~AW'((1 << r.size) - 1);
      submit(r);
    end
    r.id = 2'd3; r.addr = 6'h05; r.len = 8'd255; r.size = 3'd0; r.burst = BURST_INCR;
    submit(r);
    drain(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
